// File: rtl/delta_integrator_if.sv
`default_nettype none
// ============================================================================
// Module      : delta_integrator_if
// Description : Handshake and control bundle for the delta_integrator.
//               master : upstream/downstream side (drives diffs, out_ready,
//                        load and clr_ovf; observes samples and flags)
//               slave  : the integrator itself
//               Signals:
//                 in_valid/in_ready/diff      difference input handshake
//                 load/load_value             accumulator preload strobe
//                 out_valid/out_ready/out     reconstructed sample output
//                 ovf_pulse/ovf_sticky        overflow reporting
//                 clr_ovf                     clears ovf_sticky
// Revision    : 1.0  initial release
// ============================================================================
interface delta_integrator_if #(
   parameter int DATA_WIDTH = 16
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] diff;
   logic                         load;
   logic signed [DATA_WIDTH-1:0] load_value;
   logic                         out_valid;
   logic                         out_ready;
   logic signed [DATA_WIDTH-1:0] out;
   logic                         ovf_pulse;
   logic                         ovf_sticky;
   logic                         clr_ovf;

   modport master (
      output in_valid, diff, load, load_value, out_ready, clr_ovf,
      input  in_ready, out_valid, out, ovf_pulse, ovf_sticky
   );

   modport slave (
      input  in_valid, diff, load, load_value, out_ready, clr_ovf,
      output in_ready, out_valid, out, ovf_pulse, ovf_sticky
   );
endinterface
`default_nettype wire

// File: rtl/delta_integrator.sv
`default_nettype none
// ============================================================================
// Module      : delta_integrator
// Description : Running-sum integrator reconstructing a signed sample stream
//               from first differences: out[n] = out[n-1] + diff[n].
//               Single registered output slot with valid/ready on both
//               sides, accumulator preload, optional saturation and
//               overflow reporting (one-cycle pulse plus sticky flag).
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - delta_integrator_if.slave (handshakes, load, flags)
// Revision    : 1.0  initial release
// ============================================================================
module delta_integrator #(
   parameter int DATA_WIDTH = 16,
   parameter bit SAT_EN     = 1'b1
) (
   input  wire logic        clk,
   input  wire logic        rst,
   delta_integrator_if.slave bus
);

   localparam logic signed [DATA_WIDTH-1:0] c_SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] c_SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic signed [DATA_WIDTH-1:0] r_acc;
   logic signed [DATA_WIDTH-1:0] r_out;
   logic                         r_out_valid;
   logic                         r_ovf_pulse;
   logic                         r_ovf_sticky;

   logic                         w_in_ready;
   logic                         w_accept;
   logic        [DATA_WIDTH:0]   w_sum;
   logic                         w_ovf;
   logic signed [DATA_WIDTH-1:0] w_result;

   // The slot can take a new diff when it is empty or being drained this
   // same cycle; a preload blocks acceptance so the diff is held, not lost.
   assign w_in_ready = !bus.load && (!r_out_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;

   // Exact sum one bit wider than the operands; the two top bits disagree
   // exactly when the true result does not fit in DATA_WIDTH.
   assign w_sum = {r_acc[DATA_WIDTH-1], r_acc} + {bus.diff[DATA_WIDTH-1], bus.diff};
   assign w_ovf = w_sum[DATA_WIDTH] ^ w_sum[DATA_WIDTH-1];

   generate
      if (SAT_EN) begin : g_sat
         // The extended sign bit tells which rail the exact sum crossed.
         assign w_result = w_ovf ? (w_sum[DATA_WIDTH] ? c_SAT_MIN : c_SAT_MAX)
                                 : w_sum[DATA_WIDTH-1:0];
      end else begin : g_wrap
         assign w_result = w_sum[DATA_WIDTH-1:0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc        <= '0;
         r_out        <= '0;
         r_out_valid  <= 1'b0;
         r_ovf_pulse  <= 1'b0;
         r_ovf_sticky <= 1'b0;
      end else begin
         // Accumulator: preload and accept never coincide (in_ready is low
         // during load), so the order here only documents priority.
         if (bus.load) begin
            r_acc <= bus.load_value;
         end else if (w_accept) begin
            r_acc <= w_result;
         end

         if (w_accept) begin
            r_out       <= w_result;
            r_out_valid <= 1'b1;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end

         r_ovf_pulse <= w_accept && w_ovf;

         // A fresh overflow outranks a simultaneous clear.
         if (w_accept && w_ovf) begin
            r_ovf_sticky <= 1'b1;
         end else if (bus.clr_ovf) begin
            r_ovf_sticky <= 1'b0;
         end
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out        = r_out;
   assign bus.out_valid  = r_out_valid;
   assign bus.ovf_pulse  = r_ovf_pulse;
   assign bus.ovf_sticky = r_ovf_sticky;

endmodule
`default_nettype wire

// File: doc/delta_integrator.md
# delta_integrator

Running-sum integrator that reconstructs a signed sample stream from first differences (out[n] = out[n-1] + diff[n]); the decode-side counterpart of the Diff differentiator. Sits downstream of a delta-coded link: each accepted difference updates a DATA_WIDTH accumulator and emits one reconstructed sample. Has valid/ready handshakes on both sides, an accumulator preload for resync, and optional saturation with overflow reporting.

## Interface
- DATA_WIDTH, 16: width of diff, load_value, out (two's complement).
- SAT_EN, 1: 1 = clamp sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; 0 = wrap modulo 2^DATA_WIDTH.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  diff is valid this cycle.
- in_ready  out  1  block accepts diff this cycle.
- diff  in  DATA_WIDTH signed  difference sample.
- load  in  1  preload accumulator with load_value (one-cycle strobe).
- load_value  in  DATA_WIDTH signed  preload value.
- out_valid  out  1  out holds an unconsumed sample.
- out_ready  in  1  downstream consumes out this cycle.
- out  out  DATA_WIDTH signed  reconstructed sample (registered).
- ovf_pulse  out  1  high for one cycle after an accept whose exact sum left range.
- ovf_sticky  out  1  set by any overflow, cleared by clr_ovf or rst.
- clr_ovf  in  1  clears ovf_sticky.

## Operation
- State: acc (DATA_WIDTH), out register, out_valid, ovf_sticky.
- in_ready = !load && (!out_valid || out_ready) (combinational; single output slot, pass-through when drained same cycle).
- Accept = in_valid && in_ready. On accept: exact sum s = acc + diff computed at DATA_WIDTH+1 bits (sign-extend both). Overflow = s outside signed DATA_WIDTH range. Result r = clamp(s) if SAT_EN else s[DATA_WIDTH-1:0]. acc <= r, out <= r, out_valid <= 1, ovf_pulse <= overflow.
- No accept and out_ready: out_valid <= 0; out holds its last value.
- load: acc <= load_value; no sample emitted; out/out_valid unaffected except normal drain by out_ready. load has priority: in_ready is 0 during load, so a simultaneous in_valid is held off, not dropped.
- ovf_sticky: set on overflow accept; clr_ovf clears; overflow in the same cycle as clr_ovf wins (sticky stays 1).
- ovf_pulse is 0 on every cycle without an overflowing accept.
- rst: acc=0, out=0, out_valid=0, ovf_pulse=0, ovf_sticky=0. Overrides load, accept, clr_ovf. In-flight output is discarded. in_ready is 1 when rst deasserts (load low).

## Timing
- Latency: diff accepted at edge k -> out/out_valid visible after edge k (one cycle).
- Throughput: one sample/cycle while out_ready held high.
- Backpressure: out_valid && !out_ready freezes out, acc, and in_ready=0; upstream must hold diff/in_valid.
- Load at edge k affects the sum of the first diff accepted at edge k+1 or later.
- All outputs are registered except in_ready.

## Test plan
- Reset then diffs 5,5,-7,-7,12,0 with out_ready=1 -> out 5,10,3,-4,8,8 on consecutive cycles, out_valid high six cycles, ovf_sticky=0.
- SAT_EN=1: load 32760, then diff 10 -> out 32767, ovf_pulse one cycle, ovf_sticky=1; then diff -32768 from acc=-32760 (after load -32760) -> out -32768, ovf_pulse.
- SAT_EN=0: load 32760, diff 10 -> out -32766, ovf_pulse=1; clr_ovf -> ovf_sticky=0.
- Backpressure: out_ready=0 after first output 5 with diff 5 pending -> in_ready=0, out stays 5 for 3 cycles; release -> out 10 next cycle, no sample lost or duplicated.
- load and in_valid same cycle (acc=8, load_value=100, diff=1) -> no accept that cycle; next cycle accept -> out 101.
- rst mid-stream (acc=8, out_valid=1) -> next cycle out=0, out_valid=0; then diff 15 -> out 15; simultaneous clr_ovf with overflow -> ovf_sticky stays 1.
